// File: rtl/div_arb_pkg.sv
// Shared definitions for the round-robin divider arbiter (div_arbiter).
// Holds the controller state encoding and the constants the controller
// forces on a divide-by-zero response.
package div_arb_pkg;

  // Controller states: wait for a grant, evaluate the divider, offer the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Quotient reported for a zero divisor; users slice it to the dividend width.
  localparam logic [63:0] DBZ_QUOTIENT = '1;

  // Width of the optional divide-by-zero statistics counter.
  localparam int STAT_WIDTH = 16;

endpackage : div_arb_pkg

// File: rtl/div_arb_div.sv
// Unsigned combinational restoring divider shared by all requesters.
// A zero divisor yields an undefined-but-harmless result; the controller
// substitutes the divide-by-zero values in that case.
module div_arb_div #(
  parameter int DIVIDEND_WIDTH = 16,
  parameter int DIVISOR_WIDTH  = 8
) (
  input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
  input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
  output logic [DIVIDEND_WIDTH-1:0] quotient_o,
  output logic [DIVISOR_WIDTH-1:0]  remainder_o
);

  // One extra bit holds the partial remainder after each shift-in.
  logic [DIVISOR_WIDTH:0] partial;

  // Shift in one dividend bit per step, subtracting the divisor when it fits.
  always_comb begin
    // NOTE: blocking assignments here on purpose: each loop iteration must
    // see the partial remainder produced by the previous one.
    partial    = '0;
    quotient_o = '0;
    for (int i = DIVIDEND_WIDTH - 1; i >= 0; i--) begin
      partial = {partial[DIVISOR_WIDTH-1:0], dividend_i[i]};
      if (partial >= {1'b0, divisor_i}) begin
        partial       = partial - {1'b0, divisor_i};
        quotient_o[i] = 1'b1;
      end
    end
    remainder_o = partial[DIVISOR_WIDTH-1:0];
  end

endmodule : div_arb_div

// File: rtl/div_arb_rr_pick.sv
// Combinational round-robin picker: selects the first asserted request at or
// after the pointer, wrapping modulo NUM_REQ. Outputs a one-hot grant, the
// grant index and a flag telling whether any request was present.
module div_arb_rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] ptr_i,
  output logic [NUM_REQ-1:0]  grant_o,
  output logic [ID_WIDTH-1:0] idx_o,
  output logic                any_o
);

  // Scan the requesters starting at the pointer; the first hit wins.
  always_comb begin
    int slot;
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    slot    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      slot = (int'(ptr_i) + i) % NUM_REQ;
      if (!any_o && req_i[slot]) begin
        any_o         = 1'b1;
        grant_o[slot] = 1'b1;
        idx_o         = ID_WIDTH'(slot);
      end
    end
  end

endmodule : div_arb_rr_pick

// File: rtl/div_arbiter.sv
// Round-robin scheduler sharing one combinational divider among NUM_REQ
// requesters. One transaction is in flight at a time: IDLE grants and
// captures operands, CALC registers the divider result, RESP holds it until
// the consumer accepts. Optional build macro DIV_ARB_STATS_EN adds a
// saturating divide-by-zero response counter on port stat_dbz_count.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int DIVIDEND_WIDTH = 16,
  parameter  int DIVISOR_WIDTH  = 8,
  localparam int ID_WIDTH       = $clog2(NUM_REQ)
) (
  input  logic                                     clock,
  input  logic                                     reset_n,
  input  logic [NUM_REQ-1:0]                       req_valid,
  output logic [NUM_REQ-1:0]                       req_ready,
  input  logic [NUM_REQ-1:0][DIVIDEND_WIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ-1:0][DIVISOR_WIDTH-1:0]    req_divisor,
  output logic                                     rsp_valid,
  input  logic                                     rsp_ready,
  output logic [ID_WIDTH-1:0]                      rsp_id,
  output logic [DIVIDEND_WIDTH-1:0]                rsp_quotient,
  output logic [DIVISOR_WIDTH-1:0]                 rsp_remainder,
  output logic                                     rsp_overflow,
  output logic                                     busy
`ifdef DIV_ARB_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]                    stat_dbz_count
`endif
);

  state_e                    state_q;
  logic [ID_WIDTH-1:0]       ptr_q;
  logic [ID_WIDTH-1:0]       ptr_d;
  logic [DIVIDEND_WIDTH-1:0] op_dividend_q;
  logic [DIVISOR_WIDTH-1:0]  op_divisor_q;
  logic [ID_WIDTH-1:0]       op_id_q;

  logic [NUM_REQ-1:0]        pick_grant;
  logic [ID_WIDTH-1:0]       pick_idx;
  logic                      pick_any;
  logic [DIVIDEND_WIDTH-1:0] div_quotient;
  logic [DIVISOR_WIDTH-1:0]  div_remainder;

  div_arb_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  div_arb_div #(
    .DIVIDEND_WIDTH (DIVIDEND_WIDTH),
    .DIVISOR_WIDTH  (DIVISOR_WIDTH)
  ) u_div (
    .dividend_i  (op_dividend_q),
    .divisor_i   (op_divisor_q),
    .quotient_o  (div_quotient),
    .remainder_o (div_remainder)
  );

  // Grants are only offered while idle; in IDLE a grant is the handshake.
  assign req_ready = (state_q == IDLE) ? pick_grant : '0;
  assign busy      = (state_q != IDLE);

  // The requester after the one just served gets first priority next time.
  assign ptr_d = (op_id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : op_id_q + ID_WIDTH'(1);

  // Controller FSM with registered response outputs.
  // NOTE: asynchronous reset clears every register here, so a transaction in
  // flight is dropped at once and no stale response can appear afterwards.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      op_dividend_q <= '0;
      op_divisor_q  <= '0;
      op_id_q       <= '0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_overflow  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            op_dividend_q <= req_dividend[pick_idx];
            op_divisor_q  <= req_divisor[pick_idx];
            op_id_q       <= pick_idx;
            state_q       <= CALC;
          end
        end
        CALC: begin
          rsp_id    <= op_id_q;
          rsp_valid <= 1'b1;
          if (op_divisor_q == '0) begin
            rsp_overflow  <= 1'b1;
            rsp_quotient  <= DBZ_QUOTIENT[DIVIDEND_WIDTH-1:0];
            rsp_remainder <= '0;
          end else begin
            rsp_overflow  <= 1'b0;
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr_q     <= ptr_d;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DIV_ARB_STATS_EN
  // Saturating count of divide-by-zero responses accepted by the consumer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_dbz_count <= '0;
    end else if (rsp_valid && rsp_ready && rsp_overflow && (stat_dbz_count != '1)) begin
      stat_dbz_count <= stat_dbz_count + STAT_WIDTH'(1);
    end
  end
`else
  // Statistics disabled: no counter and no extra port.
`endif

endmodule : div_arbiter

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: a reference model predicts grants and
// pushes expected responses into a scoreboard; a separate monitor pops and
// compares each response accepted by the consumer. Directed scenarios are
// followed by a randomized sweep. Honours DIV_ARB_STATS_EN when defined.
module tb_div_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int VW = 8;

  typedef struct {
    int          id;
    logic [DW-1:0] dvd;
    logic [VW-1:0] dvs;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic        ovf;
  } exp_t;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [N-1:0][DW-1:0]  req_dividend;
  logic [N-1:0][VW-1:0]  req_divisor;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [DW-1:0]         rsp_quotient;
  logic [VW-1:0]         rsp_remainder;
  logic                  rsp_overflow;
  logic                  busy;
`ifdef DIV_ARB_STATS_EN
  logic [15:0]           stat_dbz_count;
`endif

  int checks = 0;
  int errors = 0;

  exp_t sb_q[$];

  div_arbiter #(
    .NUM_REQ        (N),
    .DIVIDEND_WIDTH (DW),
    .DIVISOR_WIDTH  (VW)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_overflow  (rsp_overflow),
    .busy          (busy)
`ifdef DIV_ARB_STATS_EN
    ,
    .stat_dbz_count(stat_dbz_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT at %0t", name, $time);
  endtask

  // Expected result straight from the arithmetic definition.
  function automatic exp_t model_div(input int id, input logic [DW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
    e.id  = id;
    e.dvd = a;
    e.dvs = b;
    if (b == 0) begin
      e.q   = '1;
      e.r   = '0;
      e.ovf = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int idx = -1;
    for (int i = 0; i < N; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  // ---------------------------------------------------------------- model
  // Transaction-level model: one job at a time, first valid requester at or
  // after the pointer wins, pointer moves past the winner once its result
  // has been accepted. Pushes expectations at each handshake.
  bit in_flight_m = 0;
  int ptr_m       = 0;
  int cur_id_m    = 0;
  int age_m       = 0;

  always @(negedge clock) begin
    if (!reset_n) begin
      in_flight_m = 0;
      ptr_m       = 0;
      age_m       = 0;
      sb_q.delete();
      check("reset_rsp_valid", 32'(rsp_valid), 0);
      check("reset_busy", 32'(busy), 0);
    end else if (!in_flight_m) begin
      logic [N-1:0] exp_ready;
      int           win;
      exp_ready = '0;
      win       = -1;
      for (int k = 0; k < N; k++) begin
        if (win < 0 && req_valid[(ptr_m + k) % N]) win = (ptr_m + k) % N;
      end
      if (win >= 0) exp_ready[win] = 1'b1;
      check("idle_req_ready", 32'(req_ready), 32'(exp_ready));
      check("idle_busy", 32'(busy), 0);
      check("idle_rsp_valid", 32'(rsp_valid), 0);
      if (win >= 0) begin
        sb_q.push_back(model_div(win, req_dividend[win], req_divisor[win]));
        in_flight_m = 1;
        cur_id_m    = win;
        age_m       = 0;
      end
    end else begin
      age_m++;
      check("active_req_ready", 32'(req_ready), 0);
      check("active_busy", 32'(busy), 1);
      check("rsp_valid_latency", 32'(rsp_valid), (age_m >= 2) ? 1 : 0);
      if (rsp_valid && rsp_ready) begin
        in_flight_m = 0;
        ptr_m       = (cur_id_m + 1) % N;
      end
    end
  end

  // -------------------------------------------------------------- monitor
  exp_t          e_mon;
  bit            held = 0;
  bit            stat_pend = 0;
  int            exp_stat = 0;
  logic [1:0]    sv_id;
  logic [DW-1:0] sv_q;
  logic [VW-1:0] sv_r;
  logic          sv_ovf;

  always @(negedge clock) begin
    if (!reset_n) begin
      held      = 0;
      stat_pend = 0;
      exp_stat  = 0;
    end else begin
`ifdef DIV_ARB_STATS_EN
      if (stat_pend) check("stat_dbz_count", 32'(stat_dbz_count), 32'(exp_stat));
`endif
      stat_pend = 0;
      if (held) begin
        check("stall_rsp_id", 32'(rsp_id), 32'(sv_id));
        check("stall_rsp_quotient", 32'(rsp_quotient), 32'(sv_q));
        check("stall_rsp_remainder", 32'(rsp_remainder), 32'(sv_r));
        check("stall_rsp_overflow", 32'(rsp_overflow), 32'(sv_ovf));
      end
      held = 0;
      if (rsp_valid) begin
        if (rsp_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: id %0d with nothing outstanding at %0t", rsp_id, $time);
          end else begin
            e_mon = sb_q.pop_front();
            check("rsp_id", 32'(rsp_id), 32'(e_mon.id));
            check("rsp_quotient", 32'(rsp_quotient), 32'(e_mon.q));
            check("rsp_remainder", 32'(rsp_remainder), 32'(e_mon.r));
            check("rsp_overflow", 32'(rsp_overflow), 32'(e_mon.ovf));
            if (!e_mon.ovf) begin
              check("rsp_identity", 32'(rsp_quotient) * 32'(e_mon.dvs) + 32'(rsp_remainder), 32'(e_mon.dvd));
              check("rsp_rem_below_divisor", 32'(rsp_remainder < e_mon.dvs), 1);
            end else begin
              if (exp_stat < 65535) exp_stat++;
              stat_pend = 1;
            end
          end
        end else begin
          held   = 1;
          sv_id  = rsp_id;
          sv_q   = rsp_quotient;
          sv_r   = rsp_remainder;
          sv_ovf = rsp_overflow;
        end
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic do_req(input int idx, input logic [DW-1:0] a, input logic [VW-1:0] b);
    bit ok = 0;
    @(posedge clock); #1;
    req_valid[idx]    = 1'b1;
    req_dividend[idx] = a;
    req_divisor[idx]  = b;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clock);
      if (req_ready[idx]) ok = 1;
    end
    if (!ok) fail_timeout("do_req_handshake");
    @(posedge clock); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_grant(input int idx);
    bit ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clock);
      if (req_ready[idx]) ok = 1;
    end
    if (!ok) fail_timeout("wait_grant");
  endtask

  task automatic wait_rsp(output int cycles);
    bit ok = 0;
    cycles = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clock);
      cycles++;
      if (rsp_valid) ok = 1;
    end
    if (!ok) fail_timeout("wait_rsp");
  endtask

  task automatic drain();
    bit           done = 0;
    logic [N-1:0] hs;
    rsp_ready = 1'b1;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clock);
      hs = req_valid & req_ready;
      if (req_valid == '0 && !busy && !rsp_valid) begin
        done = 1;
      end else begin
        @(posedge clock); #1;
        req_valid = req_valid & ~hs;
      end
    end
    if (!done) fail_timeout("drain");
  endtask

  task automatic apply_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    @(posedge clock); #2;
    reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat;
    int           got[$];
    logic [N-1:0] g;
    logic [N-1:0] hs;

    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = 1'b1;

    // Reset values.
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_quotient", 32'(rsp_quotient), 0);
    check("rst_rsp_remainder", 32'(rsp_remainder), 0);
    check("rst_rsp_overflow", 32'(rsp_overflow), 0);
    check("rst_busy", 32'(busy), 0);
`ifdef DIV_ARB_STATS_EN
    check("rst_stat", 32'(stat_dbz_count), 0);
`endif
    repeat (2) @(negedge clock);
    @(posedge clock); #2;
    reset_n = 1'b1;

    // Single request: 200 / 7.
    do_req(0, 16'd200, 8'd7);
    wait_rsp(lat);
    check("single_latency", 32'(lat), 2);
    check("single_quotient", 32'(rsp_quotient), 28);
    check("single_remainder", 32'(rsp_remainder), 4);
    check("single_id", 32'(rsp_id), 0);
    check("single_overflow", 32'(rsp_overflow), 0);

    // Divide by zero on requester 2.
    do_req(2, 16'h1234, 8'd0);
    wait_rsp(lat);
    check("dbz_overflow", 32'(rsp_overflow), 1);
    check("dbz_quotient", 32'(rsp_quotient), 32'h0000_FFFF);
    check("dbz_remainder", 32'(rsp_remainder), 0);
    check("dbz_id", 32'(rsp_id), 2);
    @(negedge clock);
`ifdef DIV_ARB_STATS_EN
    check("dbz_stat", 32'(stat_dbz_count), 1);
`endif

    // Fairness: all requesters held valid from pointer 0.
    apply_reset();
    for (int i = 0; i < N; i++) begin
      req_dividend[i] = DW'(1000 * i + 5);
      req_divisor[i]  = VW'(i + 3);
    end
    req_valid = '1;
    for (int k = 0; k < 60 && got.size() < 5; k++) begin
      @(negedge clock);
      g = req_valid & req_ready;
      if (g != '0) got.push_back(onehot_idx(g));
    end
    if (got.size() < 5) fail_timeout("fairness_grants");
    for (int k = 0; k < got.size(); k++) check($sformatf("fair_grant%0d", k), 32'(got[k]), 32'(k % N));
    drain();

    // Backpressure: result held for several cycles with others waiting.
    rsp_ready = 1'b0;
    do_req(1, 16'hBEEF, 8'd13);
    req_valid[0] = 1'b1; req_dividend[0] = 16'd999;   req_divisor[0] = 8'd10;
    req_valid[3] = 1'b1; req_dividend[3] = 16'd50000; req_divisor[3] = 8'd0;
    wait_rsp(lat);
    check("bp_quotient", 32'(rsp_quotient), 32'(16'hBEEF / 13));
    check("bp_remainder", 32'(rsp_remainder), 32'(16'hBEEF % 13));
    repeat (5) begin
      @(negedge clock);
      check("bp_rsp_valid_held", 32'(rsp_valid), 1);
      check("bp_req_ready_zero", 32'(req_ready), 0);
    end
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    @(negedge clock);
    check("bp_release_valid", 32'(rsp_valid), 1);
    @(negedge clock);
    check("bp_next_grant", 32'(req_ready), 32'b1000);
    @(posedge clock); #1;
    req_valid[3] = 1'b0;
    drain();

    // Reset while CALC with requester 1 pending.
    @(posedge clock); #1;
    req_valid[1] = 1'b1; req_dividend[1] = 16'd65535; req_divisor[1] = 8'd255;
    wait_grant(1);
    @(posedge clock); #1;
    check("mid_busy_calc", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    repeat (2) @(negedge clock);
    @(posedge clock); #2;
    reset_n = 1'b1;
    wait_grant(1);
    @(posedge clock); #1;
    req_valid[1] = 1'b0;
    wait_rsp(lat);
    check("mid_quotient", 32'(rsp_quotient), 257);
    check("mid_remainder", 32'(rsp_remainder), 0);
    check("mid_id", 32'(rsp_id), 1);
`ifdef DIV_ARB_STATS_EN
    check("mid_stat", 32'(stat_dbz_count), 0);
`endif
    drain();

    // Random sweep.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      hs = req_valid & req_ready;
      @(posedge clock); #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] || !req_valid[i]) begin
          req_valid[i]    = ($urandom_range(0, 2) != 0);
          req_dividend[i] = DW'($urandom);
          req_divisor[i]  = ($urandom_range(0, 7) == 0) ? '0 : VW'($urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drain();
    @(negedge clock);
    check("scoreboard_empty", 32'(sb_q.size()), 0);
`ifdef DIV_ARB_STATS_EN
    check("final_stat", 32'(stat_dbz_count), 32'(exp_stat));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_div_arbiter
